// File: rtl/axi_read_arbiter_if.sv
// AXI read channel bundle (AR + R) shared by the master ports and the slave port.
// The master modport drives AR and rready; the slave modport drives arready and R.
interface axi_read_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-address arbiter with one outstanding read; R beats are
// routed back to the granted master until the final beat is accepted.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);
  localparam int TAG_W = IDS_W - ID_W;
  localparam logic [TAG_W-1:0] TAG_M0 = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_M1 = TAG_W'(2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic              arvalid_q;
  logic [IDS_W-1:0]  arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              len_err;

  logic any_valid;
  logic winner;
  logic r_hs;
  logic unused_rid_tag;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    any_valid = m0.arvalid | m1.arvalid;
    if (m0.arvalid && m1.arvalid) winner = ~last_grant;
    else                          winner = m1.arvalid;
  end

  assign m0.arready = (state == IDLE) && m0.arvalid && !winner;
  assign m1.arready = (state == IDLE) && m1.arvalid &&  winner;

  assign s.arvalid = arvalid_q;
  assign s.arid    = arid_q;
  assign s.araddr  = araddr_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;

  // Routing relies on the grant register; the tag carried in rid is ignored.
  assign s.rready  = (state == DATA) && (grant ? m1.rready : m0.rready);
  assign m0.rvalid = (state == DATA) && !grant && s.rvalid;
  assign m1.rvalid = (state == DATA) &&  grant && s.rvalid;
  assign r_hs      = s.rvalid && s.rready;

  assign m0.rid   = s.rid[ID_W-1:0];
  assign m0.rdata = s.rdata;
  assign m0.rresp = s.rresp;
  assign m0.rlast = s.rlast;
  assign m1.rid   = s.rid[ID_W-1:0];
  assign m1.rdata = s.rdata;
  assign m1.rresp = s.rresp;
  assign m1.rlast = s.rlast;

  assign unused_rid_tag = ^s.rid[IDS_W-1:ID_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      arvalid_q  <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      beat_cnt   <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state      <= ADDR;
            grant      <= winner;
            last_grant <= winner;
            arvalid_q  <= 1'b1;
            if (winner) begin
              arid_q    <= {TAG_M1, m1.arid};
              araddr_q  <= m1.araddr;
              arlen_q   <= m1.arlen;
              arsize_q  <= m1.arsize;
              arburst_q <= m1.arburst;
            end else begin
              arid_q    <= {TAG_M0, m0.arid};
              araddr_q  <= m0.araddr;
              arlen_q   <= m0.arlen;
              arsize_q  <= m0.arsize;
              arburst_q <= m0.arburst;
            end
          end
        end
        ADDR: begin
          if (s.arready) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            // A short or long burst still terminates on rlast; only the flag records it.
            if (s.rlast) begin
              if (beat_cnt != arlen_q) len_err <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
